// File: rtl/alu_op_sequencer_if.sv
// Handshake and control-field bundle between the control FSM, the
// sequencer, the mult/div unit and the result muxes.
// slave: sequencer view (takes req/code/md_done, drives status and fields).
// master: environment view (drives req/code/md_done, observes the rest).
interface alu_op_sequencer_if #(
  parameter int CTRL_W = 5
);
  logic              req;
  logic [CTRL_W-1:0] control_type;
  logic              md_done;
  logic              busy;
  logic              done;
  logic              illegal;
  logic              md_timeout;
  logic              md_start;
  logic [1:0]        cond_type;
  logic              div_op;
  logic              mult_op;
  logic [2:0]        alu_op;
  logic              or_op;
  logic              overflow_op;
  logic [2:0]        src_out;
  logic [1:0]        store_md;

  modport slave (
    input  req, control_type, md_done,
    output busy, done, illegal, md_timeout, md_start,
           cond_type, div_op, mult_op, alu_op, or_op, overflow_op,
           src_out, store_md
  );

  modport master (
    output req, control_type, md_done,
    input  busy, done, illegal, md_timeout, md_start,
           cond_type, div_op, mult_op, alu_op, or_op, overflow_op,
           src_out, store_md
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer: decodes one op code per request and holds the fields.
// Latency accept->done: ALU_LAT+1 (ALU class), 1 (illegal), md_done cycle+1 (mult/div).
// Backpressure: req is sampled only in IDLE; it is ignored while busy, including FINISH.
// Ports: clk, reset (async, active-high); bus (slave modport) carries req/control_type/
//   md_done in and busy/done/illegal/md_timeout/md_start plus the decoded fields out.
module alu_op_sequencer #(
  parameter int CTRL_W     = 5,
  parameter int ALU_LAT    = 1,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_sequencer_if.slave bus
);

  typedef struct packed {
    logic [1:0] cond_type;
    logic       div_op;
    logic       mult_op;
    logic [2:0] alu_op;
    logic       or_op;
    logic       overflow_op;
    logic [2:0] src_out;
    logic [1:0] store_md;
  } ctrl_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_MD_WAIT = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  // Last count value of each waiting state; one shared counter serves both.
  localparam logic [15:0] ALU_LAST = 16'(ALU_LAT - 1);
  localparam logic [15:0] MD_LAST  = 16'(MD_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  logic [CTRL_W-1:0] code;
  logic [31:0]       code_val;
  ctrl_t             dec;
  logic              dec_md;
  logic              dec_illegal;

  assign code = bus.control_type;

  // Decode of the incoming code; only used on the accept edge.
  always_comb begin
    dec         = '0;
    dec_md      = 1'b0;
    dec_illegal = 1'b0;
    code_val    = 32'(code);
    if (code_val <= 32'd7) begin
      dec.alu_op      = code_val[2:0];
      dec.src_out     = (code_val == 32'd7) ? 3'd2 : 3'd3;
      dec.overflow_op = (code_val == 32'd1) || (code_val == 32'd2) ||
                        (code_val == 32'd4);
    end else begin
      case (code_val)
        32'd8:  begin dec.or_op = 1'b1; dec.src_out = 3'd4; end
        32'd9:  begin dec.div_op = 1'b1; dec.store_md = 2'd1; dec_md = 1'b1; end
        32'd10: begin dec.mult_op = 1'b1; dec.store_md = 2'd2; dec_md = 1'b1; end
        32'd11: begin dec.alu_op = 3'd1; dec.src_out = 3'd3; end
        32'd12: dec.src_out = 3'd1;
        32'd13: dec.src_out = 3'd0;
        32'd14: dec.cond_type = 2'd0;
        32'd15: dec.cond_type = 2'd1;
        32'd16: dec.cond_type = 2'd2;
        32'd17: dec.cond_type = 2'd3;
        32'd18: dec.src_out = 3'd6;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cnt_d = '0;
          if (dec_illegal) begin
            // Illegal codes skip straight to FINISH with all fields at zero.
            state_d   = S_FINISH;
            illegal_d = 1'b1;
            ctrl_d    = '0;
          end else begin
            ctrl_d  = dec;
            state_d = dec_md ? S_MD_WAIT : S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q >= ALU_LAST) state_d = S_FINISH;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      S_MD_WAIT: begin
        // md_done wins over an expiring watchdog in the same cycle.
        if (bus.md_done) begin
          state_d = S_FINISH;
        end else if (cnt_q >= MD_LAST) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        ctrl_d    = '0;
        cnt_d     = '0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // All outputs come straight from flops, so reset clears them immediately.
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FINISH);
  assign bus.illegal     = (state_q == S_FINISH) && illegal_q;
  assign bus.md_timeout  = (state_q == S_FINISH) && timeout_q;
  assign bus.md_start    = (state_q == S_MD_WAIT) && (cnt_q == 16'd0);
  assign bus.cond_type   = ctrl_q.cond_type;
  assign bus.div_op      = ctrl_q.div_op;
  assign bus.mult_op     = ctrl_q.mult_op;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.or_op       = ctrl_q.or_op;
  assign bus.overflow_op = ctrl_q.overflow_op;
  assign bus.src_out     = ctrl_q.src_out;
  assign bus.store_md    = ctrl_q.store_md;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a completion scoreboard.
// Latency: checks exact accept->done cycle counts for each op class.
// Backpressure: exercises req held high through FINISH and the IDLE bubble.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [1:0] cond;
    logic       div;
    logic       mult;
    logic [2:0] alu;
    logic       orr;
    logic       ovf;
    logic [2:0] src;
    logic [1:0] st;
    logic       ill;
    logic       tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  alu_op_sequencer_if #(.CTRL_W(5)) bus ();

  alu_op_sequencer #(.CTRL_W(5), .ALU_LAT(1), .MD_TIMEOUT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference decode table written out code by code.
  function automatic exp_t model(input int c);
    exp_t e;
    e = '0;
    case (c)
      0:  begin e.alu = 3'd0; e.src = 3'd3; end
      1:  begin e.alu = 3'd1; e.src = 3'd3; e.ovf = 1'b1; end
      2:  begin e.alu = 3'd2; e.src = 3'd3; e.ovf = 1'b1; end
      3:  begin e.alu = 3'd3; e.src = 3'd3; end
      4:  begin e.alu = 3'd4; e.src = 3'd3; e.ovf = 1'b1; end
      5:  begin e.alu = 3'd5; e.src = 3'd3; end
      6:  begin e.alu = 3'd6; e.src = 3'd3; end
      7:  begin e.alu = 3'd7; e.src = 3'd2; end
      8:  begin e.orr = 1'b1; e.src = 3'd4; end
      9:  begin e.div = 1'b1; e.st = 2'd1; end
      10: begin e.mult = 1'b1; e.st = 2'd2; end
      11: begin e.alu = 3'd1; e.src = 3'd3; end
      12: e.src = 3'd1;
      13: e.src = 3'd0;
      14: e.cond = 2'd0;
      15: e.cond = 2'd1;
      16: e.cond = 2'd2;
      17: e.cond = 2'd3;
      18: e.src = 3'd6;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.cond = bus.cond_type;
    o.div  = bus.div_op;
    o.mult = bus.mult_op;
    o.alu  = bus.alu_op;
    o.orr  = bus.or_op;
    o.ovf  = bus.overflow_op;
    o.src  = bus.src_out;
    o.st   = bus.store_md;
    o.ill  = bus.illegal;
    o.tmo  = bus.md_timeout;
    return o;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input exp_t obs, input exp_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request in IDLE; returns at the sample point of the first cycle after accept.
  task automatic accept(input int c, input logic tmo);
    exp_t e;
    e = model(c);
    e.tmo = tmo;
    bus.req = 1'b1;
    bus.control_type = 5'(c);
    sb.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  // Fields expected while the op is in flight (no status pulses yet).
  task automatic chk_held(input string tag, input int c);
    exp_t e;
    e = model(c);
    e.ill = 1'b0;
    e.tmo = 1'b0;
    chk_vec({tag, " fields"}, observed(), e);
    chk_bit({tag, " busy"}, bus.busy, 1'b1);
  endtask

  // budget 0 demands done in the current cycle.
  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk_bit({tag, " done"}, bus.done, 1'b1);
    chk_vec({tag, " result"}, observed(), e);
    chk_bit({tag, " busy@finish"}, bus.busy, 1'b1);
  endtask

  task automatic chk_idle(input string tag);
    chk_vec({tag, " idle fields"}, observed(), exp_t'(0));
    chk_bit({tag, " idle busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b0;
    bus.control_type = '0;
    bus.md_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk_bit("reset done", bus.done, 1'b0);
    chk_bit("reset md_start", bus.md_start, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // ALU op c=2: fields next cycle, done the cycle after, then clear.
    accept(2, 1'b0);
    chk_held("alu2", 2);
    chk_bit("alu2 no early done", bus.done, 1'b0);
    @(negedge clk);
    wait_done("alu2", 0);
    @(negedge clk);
    chk_idle("alu2");

    // Sweep single-cycle-class codes.
    for (int c = 0; c <= 18; c++) begin
      if (c == 9 || c == 10) continue;
      accept(c, 1'b0);
      chk_held($sformatf("sweep%0d", c), c);
      @(negedge clk);
      wait_done($sformatf("sweep%0d", c), 0);
      @(negedge clk);
    end
    chk_idle("sweep end");

    // Multiply with md_done 5 cycles after md_start.
    accept(10, 1'b0);
    chk_bit("mul md_start", bus.md_start, 1'b1);
    chk_held("mul m0", 10);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk_bit($sformatf("mul md_start off %0d", k), bus.md_start, 1'b0);
      chk_held($sformatf("mul m%0d", k), 10);
      chk_bit($sformatf("mul no done %0d", k), bus.done, 1'b0);
      if (k == 5) bus.md_done = 1'b1;
    end
    @(negedge clk);
    bus.md_done = 1'b0;
    wait_done("mul", 0);
    @(negedge clk);
    chk_idle("mul");

    // md_done in the same cycle as md_start.
    accept(10, 1'b0);
    chk_bit("mul0 md_start", bus.md_start, 1'b1);
    bus.md_done = 1'b1;
    @(negedge clk);
    bus.md_done = 1'b0;
    wait_done("mul0", 0);
    @(negedge clk);

    // Divide, watchdog expiry after 8 MD_WAIT cycles.
    accept(9, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk_bit($sformatf("tmo wait %0d", k), bus.done, 1'b0);
    end
    chk_held("tmo last", 9);
    @(negedge clk);
    wait_done("tmo", 0);
    @(negedge clk);
    chk_idle("tmo");

    // md_done in the expiry cycle counts as success.
    accept(9, 1'b0);
    for (int k = 1; k <= 7; k++) @(negedge clk);
    bus.md_done = 1'b1;
    @(negedge clk);
    bus.md_done = 1'b0;
    wait_done("tmo_race", 0);
    @(negedge clk);

    // Illegal code goes straight to FINISH.
    accept(25, 1'b0);
    wait_done("ill25", 0);
    @(negedge clk);
    chk_bit("ill25 clears", bus.illegal, 1'b0);

    // Back-to-back with req held high; FINISH request must be ignored.
    bus.req = 1'b1;
    bus.control_type = 5'd0;
    sb.push_back(model(0));
    @(negedge clk);
    bus.control_type = 5'd14;
    sb.push_back(model(14));
    chk_held("b2b first", 0);
    @(negedge clk);
    wait_done("b2b first", 0);
    @(negedge clk);
    chk_idle("b2b bubble");
    @(negedge clk);
    bus.req = 1'b0;
    chk_held("b2b second", 14);
    @(negedge clk);
    wait_done("b2b second", 0);
    @(negedge clk);
    chk_idle("b2b end");

    // Asynchronous reset in the middle of MD_WAIT.
    bus.req = 1'b1;
    bus.control_type = 5'd9;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    chk_bit("pre-reset busy", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_idle("async reset");
    chk_bit("async reset done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_bit("post-reset busy", bus.busy, 1'b0);
    bus.md_done = 1'b1;
    @(negedge clk);
    bus.md_done = 1'b0;
    chk_bit("stray md_done no done", bus.done, 1'b0);
    @(negedge clk);
    chk_bit("stray md_done no done later", bus.done, 1'b0);
    chk_bit("scoreboard drained", sb.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
